dmem_stall_responder: RTL and testbench
=======================================

# dmem_stall_responder

Multi-cycle data-memory responder for the pipelined CPU's MEM stage. It accepts one load or store per transaction from the MemRead/MemWrite request interface and holds the pipeline with a stall signal for a parameterised access latency. It completes each request with a one-cycle acknowledge. It is the responder end of the CPU's data-memory request interface and replaces the zero-wait data memory when latency modelling is required.

## Interface
- DEPTH, 128, number of 32-bit words; power of two, >= 2
- LATENCY, 2, cycles from request acceptance to acknowledge; integer >= 1
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- addr_i  in  32  byte address from the EX/MEM ALU result
- data_i  in  32  store data from EX/MEM
- MemRead_i  in  1  load request
- MemWrite_i  in  1  store request
- data_o  out  32  load data, registered
- stall_o  out  1  freezes PC and all pipeline registers while high
- ack_o  out  1  one-cycle pulse marking transaction completion
- misalign_o  out  1  sticky error flag: misaligned access or conflicting request seen

## Operation
- States: IDLE, WAIT, DONE.
- A request is MemRead_i | MemWrite_i.
  - If both are high, the request is a store, and misalign_o is set.
- IDLE with a request:
  - stall_o = 1, combinational from the request inputs.
  - Latch the address, data and type on the clock edge.
  - Load cnt = LATENCY-1.
  - Next state is WAIT if cnt != 0, else DONE.
- IDLE with no request: stall_o = 0, remain in IDLE.
- WAIT:
  - stall_o = 1 and cnt decrements each cycle.
  - When cnt == 1 at the edge, next state is DONE.
  - Request inputs are ignored; the latched copy is used.
- Leaving for DONE (edge that enters DONE):
  - A store writes the latched data to the word.
  - A load registers the word into data_o.
- DONE: ack_o = 1 and stall_o = 0 (the pipeline advances this cycle). Next state is always IDLE.
  - A request still present in DONE is not re-accepted.
  - The next request is sampled in the following IDLE cycle.
- Word index = latched addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- Misaligned access (addr[1:0] != 0):
  - A store writes nothing.
  - A load sets data_o to 0.
  - misalign_o is set, and the transaction still acks after normal latency.
- data_o holds the last load result through stores and idle cycles.
- misalign_o clears only on reset.

## Timing
- Reset values: state IDLE, cnt 0, data_o 0, ack_o 0, misalign_o 0, all memory words 0.
  - stall_o is 0 unless a request is present in IDLE.
- Latency: with a request first seen in cycle 0, stall_o is high in cycles 0..LATENCY-1, ack_o is high in cycle LATENCY, and data_o is valid from cycle LATENCY.
- LATENCY = 1: IDLE -> DONE directly, one stall cycle.
- Throughput: at most one transaction per LATENCY+1 cycles. Back-to-back requests see IDLE between DONE and the next acceptance.
- Reset asserted mid-transaction (WAIT or DONE entry pending):
  - Immediately returns to IDLE with ack_o = 0 and stall_o = 0 (given no request present).
  - A store not yet committed is discarded.
- A store followed by a load to the same word returns the new data; the commit precedes the later load's read.

## Test plan
- Reset, LATENCY=2, store 0xDEADBEEF at addr 0x10, then load 0x10:
  - stall_o is high for 2 cycles per access.
  - ack_o pulses in cycle 2 of each access.
  - data_o = 0xDEADBEEF at the second ack.
- LATENCY=1, loads from addr 0x0, 0x4 and 0x8 held back-to-back under stall (all words 0 after reset):
  - Each access gives stall 1 cycle, ack 1 cycle, then IDLE.
  - 3 acks occur in 6 cycles.
  - data_o = 0.
- Store 0x12345678 to addr 0x6 (misaligned):
  - The ack still occurs.
  - misalign_o = 1 and stays 1.
  - A later aligned load of 0x4 returns 0.
- Store 0xA5A5A5A5 to addr 4*DEPTH+8, then load addr 0x8:
  - Returns 0xA5A5A5A5 (wrap).
- Store to 0x20 with LATENCY=4, rst_i pulsed in cycle 2:
  - Outputs return to reset values asynchronously.
  - A subsequent load of 0x20 returns 0.
- MemRead_i and MemWrite_i both high with data 0x55, addr 0x0:
  - Treated as a store, misalign_o = 1.
  - A load of 0x0 returns 0x55.

Source files
------------

// File: rtl/dmem_stall_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_stall_responder_if
// Data-memory request/response bundle between the CPU MEM stage (master)
// and the multi-cycle data memory responder (slave).
//   addr_i      byte address of the access
//   data_i      store data
//   MemRead_i   load request
//   MemWrite_i  store request
//   data_o      registered load data
//   stall_o     pipeline freeze while an access is in flight
//   ack_o       one-cycle completion pulse
//   misalign_o  sticky error flag (misaligned or conflicting request)
// ----------------------------------------------------------------------------
interface dmem_stall_responder_if;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        misalign_o;

    modport master (
        output addr_i, data_i, MemRead_i, MemWrite_i,
        input  data_o, stall_o, ack_o, misalign_o
    );

    modport slave (
        input  addr_i, data_i, MemRead_i, MemWrite_i,
        output data_o, stall_o, ack_o, misalign_o
    );
endinterface

// File: rtl/dmem_stall_responder.sv
// ----------------------------------------------------------------------------
// dmem_stall_responder
// Multi-cycle data memory for the MEM stage. Accepts one load/store per
// transaction, stalls the pipeline for LATENCY cycles, then acknowledges
// for one cycle. Stores commit and loads capture on the edge entering DONE.
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset (also clears the memory array)
//   bus    slave side of dmem_stall_responder_if
// Parameters:
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  cycles from acceptance to acknowledge (>= 1)
// ----------------------------------------------------------------------------
module dmem_stall_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dmem_stall_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_data;
    logic            r_we;
    logic [31:0]     r_rdata;
    logic            r_ack;
    logic            r_misalign;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_stall;
    logic            w_commit;
    logic [AW+1:0]   w_addr;
    logic [31:0]     w_wdata;
    logic            w_we;
    logic [AW-1:0]   w_idx;
    logic            w_mis;
    logic            w_unused;

    // Upper address bits are don't-care: addresses wrap modulo 4*DEPTH.
    assign w_unused = ^bus.addr_i[31:AW+2];

    always_comb begin
        w_req   = bus.MemRead_i | bus.MemWrite_i;
        w_stall = (r_state == S_IDLE && w_req) || (r_state == S_WAIT);
        // With LATENCY == 1 the commit edge is the acceptance edge, so the
        // live inputs stand in for the not-yet-latched copy.
        if (r_state == S_IDLE) begin
            w_addr  = bus.addr_i[AW+1:0];
            w_wdata = bus.data_i;
            w_we    = bus.MemWrite_i;
        end else begin
            w_addr  = r_addr;
            w_wdata = r_data;
            w_we    = r_we;
        end
        w_commit = (r_state == S_IDLE && w_req && LATENCY == 1) ||
                   (r_state == S_WAIT && r_cnt == CW'(1));
        w_idx    = w_addr[AW+1:2];
        w_mis    = (w_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
            r_misalign <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= w_addr;
                        r_data  <= w_wdata;
                        r_we    <= w_we;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_state <= (LATENCY == 1) ? S_DONE : S_WAIT;
                        // Read and write together resolve to a store.
                        if (bus.MemRead_i && bus.MemWrite_i) begin
                            r_misalign <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_commit) begin
                r_ack <= 1'b1;
                if (w_mis) begin
                    r_misalign <= 1'b1;
                end else if (w_we) begin
                    r_mem[w_idx] <= w_wdata;
                end
                if (!w_we) begin
                    r_rdata <= w_mis ? '0 : r_mem[w_idx];
                end
            end
        end
    end

    assign bus.data_o     = r_rdata;
    assign bus.stall_o    = w_stall;
    assign bus.ack_o      = r_ack;
    assign bus.misalign_o = r_misalign;
endmodule

// File: tb/tb_dmem_stall_responder.sv
module tb_dmem_stall_responder;
    logic clk;
    logic rst [3];

    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    logic        t_rd    [3];
    logic        t_wr    [3];
    logic [31:0] o_data  [3];
    logic        o_stall [3];
    logic        o_ack   [3];
    logic        o_mis   [3];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_stall_responder_if bus0 ();
    dmem_stall_responder_if bus1 ();
    dmem_stall_responder_if bus2 ();

    dmem_stall_responder #(.DEPTH(128), .LATENCY(2)) u_l2 (.clk_i(clk), .rst_i(rst[0]), .bus(bus0));
    dmem_stall_responder #(.DEPTH(128), .LATENCY(1)) u_l1 (.clk_i(clk), .rst_i(rst[1]), .bus(bus1));
    dmem_stall_responder #(.DEPTH(128), .LATENCY(4)) u_l4 (.clk_i(clk), .rst_i(rst[2]), .bus(bus2));

    assign bus0.addr_i = t_addr[0];  assign bus0.data_i = t_wdata[0];
    assign bus0.MemRead_i = t_rd[0]; assign bus0.MemWrite_i = t_wr[0];
    assign bus1.addr_i = t_addr[1];  assign bus1.data_i = t_wdata[1];
    assign bus1.MemRead_i = t_rd[1]; assign bus1.MemWrite_i = t_wr[1];
    assign bus2.addr_i = t_addr[2];  assign bus2.data_i = t_wdata[2];
    assign bus2.MemRead_i = t_rd[2]; assign bus2.MemWrite_i = t_wr[2];

    assign o_data[0] = bus0.data_o; assign o_stall[0] = bus0.stall_o;
    assign o_ack[0]  = bus0.ack_o;  assign o_mis[0]   = bus0.misalign_o;
    assign o_data[1] = bus1.data_o; assign o_stall[1] = bus1.stall_o;
    assign o_ack[1]  = bus1.ack_o;  assign o_mis[1]   = bus1.misalign_o;
    assign o_data[2] = bus2.data_o; assign o_stall[2] = bus2.stall_o;
    assign o_ack[2]  = bus2.ack_o;  assign o_mis[2]   = bus2.misalign_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // One transaction: request held from cycle 0 until the DONE cycle; checks
    // the stall/ack waveform and returns inside the DONE cycle.
    task automatic txn(input int d, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input int lat);
        @(negedge clk);
        t_rd[d] = rd; t_wr[d] = wr; t_addr[d] = a; t_wdata[d] = wd;
        #1;
        chk($sformatf("dut%0d a%0h stall c0", d, a), 32'(o_stall[d]), 32'd1);
        chk($sformatf("dut%0d a%0h ack c0", d, a), 32'(o_ack[d]), 32'd0);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == lat) begin
                t_rd[d] = 1'b0; t_wr[d] = 1'b0;
            end
            #1;
            chk($sformatf("dut%0d a%0h stall c%0d", d, a, c), 32'(o_stall[d]), 32'(c < lat));
            chk($sformatf("dut%0d a%0h ack c%0d", d, a, c), 32'(o_ack[d]), 32'(c == lat));
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int acks;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; t_addr[d] = '0; t_wdata[d] = '0; t_rd[d] = 1'b0; t_wr[d] = 1'b0;
        end
        vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h208, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h8,   32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h6,   32'h12345678, 32'hDEADBEEF, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h4,   32'h0,        32'h0,        1'b1};
        vecs[7] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 32'h9,   32'h0,        32'h0,        1'b1};
        vecs[9] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1};

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset dut%0d data", d),  o_data[d],         32'h0);
            chk($sformatf("reset dut%0d stall", d), 32'(o_stall[d]),   32'h0);
            chk($sformatf("reset dut%0d ack", d),   32'(o_ack[d]),     32'h0);
            chk($sformatf("reset dut%0d mis", d),   32'(o_mis[d]),     32'h0);
        end

        // LATENCY=2 vector table
        for (int i = 0; i < 10; i++) begin
            txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 2);
            chk($sformatf("vec%0d data", i), o_data[0], vecs[i].exp_data);
            chk($sformatf("vec%0d mis", i), 32'(o_mis[0]), 32'(vecs[i].exp_mis));
        end

        // LATENCY=1: loads of 0x0/0x4/0x8 with MemRead held continuously
        acks = 0;
        @(negedge clk);
        t_rd[1] = 1'b1; t_addr[1] = 32'h0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (cyc % 2 == 0) t_addr[1] = t_addr[1] + 32'd4;
            end
            #1;
            chk($sformatf("b2b stall c%0d", cyc), 32'(o_stall[1]), 32'(cyc % 2 == 0));
            chk($sformatf("b2b ack c%0d", cyc), 32'(o_ack[1]), 32'(cyc % 2 == 1));
            if (o_ack[1]) acks++;
        end
        t_rd[1] = 1'b0;
        chk("b2b ack count", 32'(acks), 32'd3);
        chk("b2b data", o_data[1], 32'h0);
        chk("b2b mis", 32'(o_mis[1]), 32'h0);

        // Conflicting request resolves to a store and flags misalign
        txn(1, 1'b1, 1'b1, 32'h0, 32'h55, 1);
        chk("conflict mis", 32'(o_mis[1]), 32'h1);
        chk("conflict data held", o_data[1], 32'h0);
        txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 1);
        chk("conflict readback", o_data[1], 32'h55);
        chk("conflict mis sticky", 32'(o_mis[1]), 32'h1);

        // LATENCY=4: populate state, then reset mid-store
        txn(2, 1'b0, 1'b1, 32'h24, 32'h77, 4);
        txn(2, 1'b1, 1'b0, 32'h24, 32'h0, 4);
        chk("l4 load 0x24", o_data[2], 32'h77);
        txn(2, 1'b0, 1'b1, 32'h25, 32'h1, 4);
        chk("l4 mis set", 32'(o_mis[2]), 32'h1);
        @(negedge clk);
        t_wr[2] = 1'b1; t_addr[2] = 32'h20; t_wdata[2] = 32'hCAFEF00D;
        #1;
        chk("abort stall c0", 32'(o_stall[2]), 32'h1);
        @(negedge clk); #1;
        chk("abort stall c1", 32'(o_stall[2]), 32'h1);
        @(negedge clk);
        rst[2] = 1'b1; t_wr[2] = 1'b0;
        #1;
        chk("abort data", o_data[2], 32'h0);
        chk("abort stall", 32'(o_stall[2]), 32'h0);
        chk("abort ack", 32'(o_ack[2]), 32'h0);
        chk("abort mis", 32'(o_mis[2]), 32'h0);
        @(negedge clk);
        rst[2] = 1'b0;
        txn(2, 1'b1, 1'b0, 32'h20, 32'h0, 4);
        chk("abort load 0x20", o_data[2], 32'h0);
        txn(2, 1'b1, 1'b0, 32'h24, 32'h0, 4);
        chk("abort load 0x24", o_data[2], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
